oam_cpu_port: RTL
=================

OAM_CPU_PORT -- requirements
Module: oam_cpu_port

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-002 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-003 SHALL have ports reg_we and reg_re, input, 1 each, one-cycle CPU write and read strobes.
REQ-004 SHALL have port reg_addr, input, 2, register select: 0=$2102 OAMADDL, 1=$2103 OAMADDH, 2=$2104 OAMDATA, 3=$2138 OAMDATAREAD.
REQ-005 SHALL have port reg_din, input, 8, CPU write data.
REQ-006 SHALL have ports reg_dout (output, 8, read data) and rd_valid (output, 1, one-cycle pulse when reg_dout is updated).
REQ-007 SHALL have port busy, output, 1, high while a read is in flight.
REQ-008 SHALL have port reload, input, 1, vblank-start pulse that restores the internal address.
REQ-009 SHALL have low-table port: lo_we (out, 1), lo_addr (out, 8, word address), lo_din (out, 16), lo_dout (in, 16, valid 1 cycle after address).
REQ-010 SHALL have high-table port: hi_we (out, 1), hi_addr (out, 5), hi_din (out, 8), hi_dout (in, 8, valid 1 cycle after address).
REQ-011 SHALL have outputs prio_rot (1) and prio_base (7): sprite priority rotation enable and first-sprite index.

Function
REQ-012 SHALL hold a 9-bit reload word address rld, a 10-bit internal byte address ba, an 8-bit low-byte latch lat, and prio_rot.
REQ-013 $2102 write SHALL set rld[7:0]=reg_din and ba={rld_new,0}.
REQ-014 $2103 write SHALL set rld[8]=reg_din[0], prio_rot=reg_din[7], and ba={rld_new,0}.
REQ-015 prio_base SHALL equal rld[7:1] when prio_rot=1, else 0; combinational from registers.
REQ-016 $2104 write with ba[9]=0 and ba[0]=0 SHALL set lat=reg_din; no memory write.
REQ-017 $2104 write with ba[9]=0 and ba[0]=1 SHALL pulse lo_we one cycle with lo_addr=ba[8:1], lo_din={reg_din,lat}.
REQ-018 $2104 write with ba[9]=1 SHALL pulse hi_we one cycle with hi_addr=ba[4:0], hi_din=reg_din (0x200-0x3FF mirrors the 32-byte high table).
REQ-019 Every accepted $2104 write SHALL increment ba by 1, modulo 1024 (0x3FF wraps to 0x000).
REQ-020 Memory write strobes SHALL assert in the cycle after the accepted reg_we, never longer than one cycle.
REQ-021 Read FSM SHALL have states IDLE, ADDR, DATA; $2138 reg_re in IDLE -> ADDR (drive lo_addr=ba[8:1] or hi_addr=ba[4:0], busy=1) -> DATA (capture byte) -> IDLE.
REQ-022 In DATA the captured byte SHALL be lo_dout[15:8] if ba[0]=1 else lo_dout[7:0] for ba[9]=0, hi_dout for ba[9]=1; reg_dout updated and rd_valid pulsed on DATA->IDLE transition, ba incremented per REQ-019.
REQ-023 Read latency SHALL be exactly 3 cycles from reg_re to rd_valid.
REQ-024 reg_we or reg_re arriving while busy=1 SHALL be ignored with no state change.
REQ-025 reg_re with reg_addr!=3 and reg_we with reg_addr=3 SHALL be ignored.
REQ-026 reload SHALL set ba={rld,0}; if coincident with an accepted $2104 write, the memory write SHALL use the old ba and reload SHALL win for the next ba.
REQ-027 reload during a read in flight SHALL not abort the read; the read completes on the captured address, and ba ends at {rld,0}.
REQ-028 $2102/$2103 write coincident with reload SHALL use the newly written rld.

Reset
REQ-029 On resetn low, asynchronously: rld=0, ba=0, lat=0, prio_rot=0, reg_dout=0, rd_valid=0, busy=0, lo_we=0, hi_we=0, FSM=IDLE.
REQ-030 Reset asserted mid-read SHALL abandon the read with no rd_valid pulse after release.
REQ-031 First edge after resetn release SHALL accept strobes normally.

Verification
REQ-032 Write $2102=0x10, $2103=0x81, reload -> ba=0x220, prio_rot=1, prio_base=0x08.
REQ-033 Addr 0, $2104 writes 0xAA,0xBB -> one lo_we with lo_addr=0x00, lo_din=0xBBAA; ba=0x002.
REQ-034 $2103=0x01, $2102=0xFF, $2104 writes 0x11,0x22 -> hi_we at hi_addr=0x1E then 0x1F; ba=0x000 after wrap.
REQ-035 After REQ-033, $2102=0, $2138 read twice -> rd_valid 3 cycles after each reg_re, reg_dout=0xAA then 0xBB; reg_we during busy dropped.
REQ-036 $2104 write coincident with reload at ba=0x005, rld=0x040 -> lo_we at lo_addr=0x02, next ba=0x080.
REQ-037 resetn low during ADDR state -> all outputs at reset values, no rd_valid after release.

Source files
------------

// File: rtl/oam_cpu_port.sv
// oam_cpu_port: CPU access port for sprite OAM (low/high tables, address reload, read pipeline)
module oam_cpu_port (
  input  logic        clk,
  input  logic        resetn,
  input  logic        reg_we,
  input  logic        reg_re,
  input  logic [1:0]  reg_addr,
  input  logic [7:0]  reg_din,
  output logic [7:0]  reg_dout,
  output logic        rd_valid,
  output logic        busy,
  input  logic        reload,
  output logic        lo_we,
  output logic [7:0]  lo_addr,
  output logic [15:0] lo_din,
  input  logic [15:0] lo_dout,
  output logic        hi_we,
  output logic [4:0]  hi_addr,
  output logic [7:0]  hi_din,
  input  logic [7:0]  hi_dout,
  output logic        prio_rot,
  output logic [6:0]  prio_base
);
  localparam logic [1:0] IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2;
  logic [1:0] state;
  logic [8:0] rld, rld_n;
  logic [9:0] ba, ba_n;
  logic [7:0] lat;
  logic [1:0] rsel;
  logic       wr_ok, rd_ok, wr_data;
  assign busy      = state != IDLE;
  assign wr_ok     = reg_we && !busy && reg_addr != 2'd3;
  assign rd_ok     = reg_re && !busy && reg_addr == 2'd3 && !wr_ok;
  assign wr_data   = wr_ok && reg_addr == 2'd2;
  assign prio_base = prio_rot ? rld[7:1] : 7'd0;
  // next reload word and byte address; a reload or address write beats the auto-increment
  always_comb begin
    rld_n = rld;
    if (wr_ok && reg_addr == 2'd0) rld_n[7:0] = reg_din;
    if (wr_ok && reg_addr == 2'd1) rld_n[8] = reg_din[0];
    ba_n = (reload || (wr_ok && !reg_addr[1])) ? {rld_n, 1'b0} : (wr_data || rd_ok) ? ba + 10'd1 : ba;
  end
  // register state, one-cycle memory strobes off the old address, and the 3-cycle read pipeline
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      rld      <= '0;
      ba       <= '0;
      lat      <= '0;
      rsel     <= '0;
      prio_rot <= 1'b0;
      reg_dout <= '0;
      rd_valid <= 1'b0;
      lo_we    <= 1'b0;
      lo_addr  <= '0;
      lo_din   <= '0;
      hi_we    <= 1'b0;
      hi_addr  <= '0;
      hi_din   <= '0;
    end else begin
      rld   <= rld_n;
      ba    <= ba_n;
      lo_we <= wr_data && !ba[9] && ba[0];
      hi_we <= wr_data && ba[9];
      if (wr_ok && reg_addr == 2'd1) prio_rot <= reg_din[7];
      if (wr_data && !ba[9] && !ba[0]) lat <= reg_din;
      if (wr_data || rd_ok) begin
        lo_addr <= ba[8:1];
        hi_addr <= ba[4:0];
        rsel    <= {ba[9], ba[0]};
      end
      if (wr_data) begin
        lo_din <= {reg_din, lat};
        hi_din <= reg_din;
      end
      rd_valid <= state == DATA;
      if (state == DATA) reg_dout <= rsel[1] ? hi_dout : rsel[0] ? lo_dout[15:8] : lo_dout[7:0];
      state <= rd_ok ? ADDR : state == ADDR ? DATA : IDLE;
    end
  end
endmodule
